// File: rtl/dcache_axi_mem_responder.sv
// dcache_axi_mem_responder: AXI4 slave memory model on the dcache port.
// Independent read/write FSMs share one dual-port word array.
module dcache_axi_mem_responder #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int ID_WIDTH     = 4,
   parameter int MEM_WORDS    = 4096,
   parameter int READ_LATENCY = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   input  logic [ID_WIDTH-1:0]     ar_id,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]              ar_len,
   input  logic [2:0]              ar_size,
   input  logic [1:0]              ar_burst,
   output logic                    r_valid,
   input  logic                    r_ready,
   output logic [ID_WIDTH-1:0]     r_id,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_last,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [ID_WIDTH-1:0]     aw_id,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]              aw_len,
   input  logic [2:0]              aw_size,
   input  logic [1:0]              aw_burst,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_last,
   output logic                    b_valid,
   input  logic                    b_ready,
   output logic [ID_WIDTH-1:0]     b_id,
   output logic [1:0]              b_resp
);

   localparam int BPB = DATA_WIDTH / 8;
   localparam int OFF = $clog2(BPB);
   localparam int IW  = $clog2(MEM_WORDS);

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_WAIT  = 2'd1;
   localparam logic [1:0] R_BURST = 2'd2;
   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_DATA  = 2'd1;
   localparam logic [1:0] W_RESP  = 2'd2;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] SLVERR = 2'd2;
   localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

   function automatic logic is_bad(
      input logic [2:0] size,
      input logic [7:0] len,
      input logic [1:0] burst
   );
      logic wrap_ok;
      wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                (len == 8'd7) || (len == 8'd15);
      return (size != 3'(OFF)) || (burst == 2'd3) ||
             ((burst == 2'd2) && !wrap_ok);
   endfunction

   // WRAP boundary is (len+1)*BPB; len+1 is a power of two here
   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0]            len,
      input logic [1:0]            burst
   );
      logic [ADDR_WIDTH-1:0] mask;
      logic [ADDR_WIDTH-1:0] inc;
      mask = ({{(ADDR_WIDTH-8){1'b0}}, len} << OFF) |
             ADDR_WIDTH'(BPB - 1);
      inc  = a + ADDR_WIDTH'(BPB);
      case (burst)
         2'd0:    return a;
         2'd2:    return (a & ~mask) | (inc & mask);
         default: return inc;
      endcase
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic                  live;

   logic [1:0]            r_state;
   logic [3:0]            lat;
   logic [ADDR_WIDTH-1:0] ra;
   logic [ADDR_WIDTH-1:0] r_nxt;
   logic [7:0]            rlen;
   logic [7:0]            rcnt;
   logic [1:0]            rburst;
   logic                  rbad;

   logic [1:0]            w_state;
   logic [ADDR_WIDTH-1:0] wa;
   logic [7:0]            wlen;
   logic [8:0]            wcnt;
   logic [1:0]            wburst;
   logic                  wbad;
   logic                  werr;
   logic                  w_hs;
   logic                  w_over;
   logic                  w_early;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_merge;

   assign ar_ready = live && (r_state == R_IDLE);
   assign r_valid  = (r_state == R_BURST);
   assign r_last   = r_valid && (rcnt == rlen);
   assign r_resp   = (r_valid && rbad) ? SLVERR : OKAY;
   assign r_nxt    = next_addr(ra, rlen, rburst);

   assign aw_ready = live && (w_state == W_IDLE);
   assign w_ready  = (w_state == W_DATA);
   assign b_valid  = (w_state == W_RESP);
   assign w_hs     = w_valid && w_ready;
   assign w_over   = wcnt > {1'b0, wlen};
   assign w_early  = w_last && (wcnt < {1'b0, wlen});
   assign w_we     = rst && w_hs && !wbad && !w_over;

   always_ff @(posedge clk) begin
      if (!rst) live <= 1'b0;
      else      live <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= R_IDLE;
         lat     <= '0;
         ra      <= '0;
         rlen    <= '0;
         rcnt    <= '0;
         rburst  <= '0;
         rbad    <= 1'b0;
         r_id    <= '0;
         r_data  <= '0;
      end else begin
         unique case (r_state)
            R_IDLE: if (ar_valid && ar_ready) begin
               r_id    <= ar_id;
               ra      <= ar_addr;
               rlen    <= ar_len;
               rburst  <= ar_burst;
               rbad    <= is_bad(ar_size, ar_len, ar_burst);
               rcnt    <= '0;
               lat     <= LAT_INIT;
               r_state <= R_WAIT;
            end
            R_WAIT: if (lat == 4'd0) begin
               r_state <= R_BURST;
               r_data  <= rbad ? '0 : mem[ra[OFF +: IW]];
            end else begin
               lat <= lat - 4'd1;
            end
            R_BURST: if (r_ready) begin
               if (rcnt == rlen) begin
                  r_state <= R_IDLE;
               end else begin
                  rcnt   <= rcnt + 8'd1;
                  ra     <= r_nxt;
                  r_data <= rbad ? '0 : mem[r_nxt[OFF +: IW]];
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      w_merge = mem[wa[OFF +: IW]];
      for (int b = 0; b < BPB; b++)
         if (w_strb[b]) w_merge[8*b +: 8] = w_data[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (w_we) mem[wa[OFF +: IW]] <= w_merge;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         w_state <= W_IDLE;
         wa      <= '0;
         wlen    <= '0;
         wcnt    <= '0;
         wburst  <= '0;
         wbad    <= 1'b0;
         werr    <= 1'b0;
         b_id    <= '0;
         b_resp  <= OKAY;
      end else begin
         unique case (w_state)
            W_IDLE: if (aw_valid && aw_ready) begin
               b_id    <= aw_id;
               wa      <= aw_addr;
               wlen    <= aw_len;
               wburst  <= aw_burst;
               wbad    <= is_bad(aw_size, aw_len, aw_burst);
               werr    <= 1'b0;
               wcnt    <= '0;
               w_state <= W_DATA;
            end
            W_DATA: if (w_hs) begin
               wa <= next_addr(wa, wlen, wburst);
               if (wcnt != 9'h1FF) wcnt <= wcnt + 9'd1;
               if (w_over) werr <= 1'b1;
               if (w_last) begin
                  b_resp  <= (wbad || werr || w_over || w_early) ?
                             SLVERR : OKAY;
                  w_state <= W_RESP;
               end
            end
            W_RESP: if (b_ready) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_axi_mem_responder.sv
// tb_dcache_axi_mem_responder: directed checks of the AXI memory responder.
// Drives at posedge+1, samples at posedge+1 before the next edge.
module tb_dcache_axi_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ar_valid, ar_ready;
   logic [3:0]  ar_id;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        r_valid, r_ready;
   logic [3:0]  r_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        aw_valid, aw_ready;
   logic [3:0]  aw_id;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        w_valid, w_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_rid;
   int          rd_n, rd_first, rd_stab, rd_to;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [1:0]  wr_resp;
   logic [3:0]  wr_bid;
   int          wr_blat, wr_to;

   dcache_axi_mem_responder dut (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id),
      .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
      .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id),
      .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id),
      .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
      .aw_burst(aw_burst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id),
      .b_resp(b_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: sim time exceeded, required finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ar_send(input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu,
                          input logic [3:0] id, output bit to);
      ar_addr = a; ar_len = len; ar_size = sz; ar_burst = bu;
      ar_id = id; ar_valid = 1'b1; to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (ar_ready) begin
            tick();
            to = 1'b0;
            break;
         end
         tick();
      end
      ar_valid = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu,
                          input logic [3:0] id, input logic [3:0] pat);
      bit          to;
      bit          done;
      bit          stalled;
      int          cyc, k;
      logic [31:0] pd;
      logic [1:0]  pr;
      logic        pl;
      rd_n = 0; rd_first = -1; rd_stab = 0; rd_to = 0;
      pd = '0; pr = '0; pl = 1'b0;
      ar_send(a, len, sz, bu, id, to);
      if (to) begin
         rd_to = 1;
         return;
      end
      cyc = 0; k = 0; stalled = 0; done = 0;
      for (int g = 0; g < 300 && !done; g++) begin
         if (r_valid) begin
            if (rd_first < 0) rd_first = cyc;
            if (stalled && (r_data !== pd || r_resp !== pr ||
                            r_last !== pl)) rd_stab++;
            pd = r_data; pr = r_resp; pl = r_last;
            r_ready = pat[k % 4];
            k++;
            if (r_ready) begin
               if (rd_n < 16) begin
                  rd_data[rd_n] = r_data;
                  rd_resp[rd_n] = r_resp;
                  rd_last[rd_n] = r_last;
               end
               rd_n++;
               rd_rid = r_id;
               if (r_last) done = 1;
            end
            stalled = !r_ready;
         end else begin
            if (stalled) rd_stab++;
            stalled = 0;
            r_ready = 1'b0;
         end
         tick();
         cyc++;
      end
      r_ready = 1'b0;
      if (!done) rd_to = 1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] bu, input logic [3:0] id,
                           input int nb, input int last_at);
      bit got;
      wr_to = 1; wr_blat = 0; wr_resp = 'x; wr_bid = 'x;
      aw_addr = a; aw_len = len; aw_size = 3'd2; aw_burst = bu;
      aw_id = id; aw_valid = 1'b1; got = 0;
      for (int i = 0; i < 20; i++) begin
         if (aw_ready) begin
            tick();
            got = 1;
            break;
         end
         tick();
      end
      aw_valid = 1'b0;
      if (!got) return;
      for (int i = 0; i < nb; i++) begin
         w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i];
         w_last = (i == last_at);
         got = 0;
         for (int j = 0; j < 20; j++) begin
            if (w_ready) begin
               tick();
               got = 1;
               break;
            end
            tick();
         end
         if (!got) begin
            w_valid = 1'b0; w_last = 1'b0;
            return;
         end
      end
      w_valid = 1'b0; w_last = 1'b0;
      for (int g = 0; g < 20; g++) begin
         wr_blat++;
         if (b_valid) begin
            wr_resp = b_resp; wr_bid = b_id; wr_to = 0;
            b_ready = 1'b1;
            tick();
            b_ready = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0;
      ar_size = 0; ar_burst = 0; r_ready = 0;
      aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
      aw_size = 0; aw_burst = 0; w_valid = 0; w_data = 0;
      w_strb = 0; w_last = 0; b_ready = 0;
      #1;
      repeat (3) tick();
      n_cmp++;
      if ({ar_ready, aw_ready, w_ready, r_valid, b_valid} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_handshake: got %b want 00000",
                  {ar_ready, aw_ready, w_ready, r_valid, b_valid});
      end
      n_cmp++;
      if (r_data !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_rdata: got %h want 0", r_data);
      end
      n_cmp++;
      if ({r_id, b_id, r_resp, b_resp} !== 12'h0) begin
         n_bad++;
         $display("FAIL reset_ids: got %h want 000",
                  {r_id, b_id, r_resp, b_resp});
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({ar_ready, aw_ready} !== 2'b11) begin
         n_bad++;
         $display("FAIL reset_release: got %b want 11",
                  {ar_ready, aw_ready});
      end
   endtask

   task automatic test_preload;
      for (int i = 0; i < 16; i++) begin
         wd[i] = 32'h100 + 32'(i);
         ws[i] = 4'hF;
      end
      do_write(32'h100, 8'd15, 2'd1, 4'h3, 16, 15);
      n_cmp++;
      if (wr_to !== 0 || wr_resp !== 2'd0 || wr_bid !== 4'h3) begin
         n_bad++;
         $display("FAIL preload_b: to %0d resp %0d id %h want 0 0 3",
                  wr_to, wr_resp, wr_bid);
      end
      n_cmp++;
      if (wr_blat !== 1) begin
         n_bad++;
         $display("FAIL preload_blat: got %0d want 1", wr_blat);
      end
   endtask

   task automatic test_incr_read;
      do_read(32'h100, 8'd15, 3'd2, 2'd1, 4'h9, 4'b1111);
      n_cmp++;
      if (rd_to !== 0 || rd_n !== 16) begin
         n_bad++;
         $display("FAIL incr_count: to %0d beats %0d want 0 16",
                  rd_to, rd_n);
      end
      n_cmp++;
      if (rd_first !== 4) begin
         n_bad++;
         $display("FAIL incr_latency: got %0d want 4", rd_first);
      end
      n_cmp++;
      if (rd_rid !== 4'h9) begin
         n_bad++;
         $display("FAIL incr_rid: got %h want 9", rd_rid);
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (rd_data[i] !== 32'h100 + 32'(i) || rd_resp[i] !== 2'd0 ||
             rd_last[i] !== (i == 15)) begin
            n_bad++;
            $display("FAIL incr_beat%0d: got %h/%0d/%b want %h/0/%b",
                     i, rd_data[i], rd_resp[i], rd_last[i],
                     32'h100 + 32'(i), (i == 15));
         end
      end
   endtask

   task automatic test_wrap_read;
      logic [31:0] exp [4];
      exp[0] = 32'h103; exp[1] = 32'h100;
      exp[2] = 32'h101; exp[3] = 32'h102;
      do_read(32'h10C, 8'd3, 3'd2, 2'd2, 4'h1, 4'b1111);
      n_cmp++;
      if (rd_to !== 0 || rd_n !== 4) begin
         n_bad++;
         $display("FAIL wrap_count: to %0d beats %0d want 0 4",
                  rd_to, rd_n);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (rd_data[i] !== exp[i] || rd_resp[i] !== 2'd0 ||
             rd_last[i] !== (i == 3)) begin
            n_bad++;
            $display("FAIL wrap_beat%0d: got %h/%0d/%b want %h/0/%b",
                     i, rd_data[i], rd_resp[i], rd_last[i], exp[i],
                     (i == 3));
         end
      end
      do_read(32'h104, 8'd2, 3'd2, 2'd0, 4'h2, 4'b1111);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rd_data[i] !== 32'h101 || rd_last[i] !== (i == 2)) begin
            n_bad++;
            $display("FAIL fixed_beat%0d: got %h/%b want 101/%b",
                     i, rd_data[i], rd_last[i], (i == 2));
         end
      end
   endtask

   task automatic test_strobe_write;
      int early;
      wd[0] = 32'h55667788; ws[0] = 4'hF;
      do_write(32'h204, 8'd0, 2'd1, 4'h4, 1, 0);
      early = 0;
      w_valid = 1'b1; w_data = 32'hBAD0BAD0; w_strb = 4'hF;
      for (int i = 0; i < 3; i++) begin
         if (w_ready) early++;
         tick();
      end
      w_valid = 1'b0;
      n_cmp++;
      if (early !== 0) begin
         n_bad++;
         $display("FAIL w_before_aw: ready cycles %0d want 0", early);
      end
      wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
      wd[1] = 32'h11223344; ws[1] = 4'h3;
      do_write(32'h200, 8'd1, 2'd1, 4'h6, 2, 1);
      n_cmp++;
      if (wr_to !== 0 || wr_resp !== 2'd0 || wr_blat !== 1 ||
          wr_bid !== 4'h6) begin
         n_bad++;
         $display("FAIL strobe_b: to %0d resp %0d lat %0d id %h want 0 0 1 6",
                  wr_to, wr_resp, wr_blat, wr_bid);
      end
      do_read(32'h200, 8'd1, 3'd2, 2'd1, 4'h0, 4'b1111);
      n_cmp++;
      if (rd_data[0] !== 32'hAABBCCDD || rd_data[1] !== 32'h55663344) begin
         n_bad++;
         $display("FAIL strobe_data: got %h %h want aabbccdd 55663344",
                  rd_data[0], rd_data[1]);
      end
   endtask

   task automatic test_backpressure;
      do_read(32'h100, 8'd3, 3'd2, 2'd1, 4'h7, 4'b1001);
      n_cmp++;
      if (rd_to !== 0 || rd_n !== 4 || rd_stab !== 0) begin
         n_bad++;
         $display("FAIL bp_flow: to %0d beats %0d unstable %0d want 0 4 0",
                  rd_to, rd_n, rd_stab);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (rd_data[i] !== 32'h100 + 32'(i) || rd_last[i] !== (i == 3)) begin
            n_bad++;
            $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i,
                     rd_data[i], rd_last[i], 32'h100 + 32'(i), (i == 3));
         end
      end
   endtask

   task automatic test_errors;
      do_read(32'h100, 8'd3, 3'd1, 2'd1, 4'h8, 4'b1111);
      n_cmp++;
      if (rd_n !== 4) begin
         n_bad++;
         $display("FAIL err_rd_count: got %0d want 4", rd_n);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'd2 ||
             rd_last[i] !== (i == 3)) begin
            n_bad++;
            $display("FAIL err_rd_beat%0d: got %h/%0d/%b want 0/2/%b",
                     i, rd_data[i], rd_resp[i], rd_last[i], (i == 3));
         end
      end
      do_read(32'h100, 8'd2, 3'd2, 2'd2, 4'h8, 4'b1111);
      n_cmp++;
      if (rd_n !== 3 || rd_resp[0] !== 2'd2 || rd_data[2] !== 32'h0) begin
         n_bad++;
         $display("FAIL err_wrap_len: beats %0d resp %0d data %h want 3 2 0",
                  rd_n, rd_resp[0], rd_data[2]);
      end
      wd[0] = 32'hDEAD0001; ws[0] = 4'hF;
      wd[1] = 32'hDEAD0002; ws[1] = 4'hF;
      do_write(32'h300, 8'd3, 2'd1, 4'hA, 2, 1);
      n_cmp++;
      if (wr_to !== 0 || wr_resp !== 2'd2) begin
         n_bad++;
         $display("FAIL err_early_last: to %0d resp %0d want 0 2",
                  wr_to, wr_resp);
      end
      do_read(32'h300, 8'd1, 3'd2, 2'd1, 4'h0, 4'b1111);
      n_cmp++;
      if (rd_data[0] !== 32'hDEAD0001 || rd_data[1] !== 32'hDEAD0002) begin
         n_bad++;
         $display("FAIL err_early_data: got %h %h want dead0001 dead0002",
                  rd_data[0], rd_data[1]);
      end
      wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
      do_write(32'h100, 8'd0, 2'd3, 4'hB, 1, 0);
      n_cmp++;
      if (wr_to !== 0 || wr_resp !== 2'd2) begin
         n_bad++;
         $display("FAIL err_bad_burst: to %0d resp %0d want 0 2",
                  wr_to, wr_resp);
      end
      do_read(32'h100, 8'd0, 3'd2, 2'd1, 4'h0, 4'b1111);
      n_cmp++;
      if (rd_data[0] !== 32'h100) begin
         n_bad++;
         $display("FAIL err_no_write: got %h want 100", rd_data[0]);
      end
   endtask

   task automatic test_reset_mid;
      bit to;
      bit hit;
      int beats, stray;
      ar_send(32'h100, 8'd7, 3'd2, 2'd1, 4'hC, to);
      beats = 0; hit = 0;
      for (int g = 0; g < 50 && !to; g++) begin
         if (r_valid) begin
            if (beats == 2) begin
               hit = 1;
               break;
            end
            r_ready = 1'b1;
            beats++;
         end else begin
            r_ready = 1'b0;
         end
         tick();
      end
      r_ready = 1'b0;
      n_cmp++;
      if (hit !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reach_beat2: got %b want 1", hit);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({r_valid, ar_ready} !== 2'b00) begin
         n_bad++;
         $display("FAIL mid_abort: got %b want 00", {r_valid, ar_ready});
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (ar_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_release: got %b want 1", ar_ready);
      end
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         if (r_valid) stray++;
         tick();
      end
      n_cmp++;
      if (stray !== 0) begin
         n_bad++;
         $display("FAIL mid_stray_r: got %0d want 0", stray);
      end
      do_read(32'h104, 8'd1, 3'd2, 2'd1, 4'hD, 4'b1111);
      n_cmp++;
      if (rd_n !== 2 || rd_data[0] !== 32'h101 || rd_data[1] !== 32'h102 ||
          rd_first !== 4) begin
         n_bad++;
         $display("FAIL mid_after: beats %0d data %h %h lat %0d want 2 101 102 4",
                  rd_n, rd_data[0], rd_data[1], rd_first);
      end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_incr_read();
      test_wrap_read();
      test_strobe_write();
      test_backpressure();
      test_errors();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
